agc_amplitude_meter: RTL
========================

// Module: agc_amplitude_meter
// PURPOSE
//  Downstream consumer of the auto-gain-control stage. Takes the raw ADC stream plus the
//  AGC gain code and reports the input-referred peak-to-peak amplitude in mV, once per
//  measurement window. It blanks measurement while the analog gain settles after a gain
//  change, and flags windows that clip. Feeds the display/measurement logic.
// PARAMETERS
//  WINDOW         512   samples per measurement window (>=2)
//  SETTLE_CYCLES  16    samples discarded after reset or any gain_ctrl change (>=1)
//  MV_OUT_W       12    width of vpp_mv
// PORTS
//  adc_clk     in   1         sample clock; one ADC sample per rising edge
//  rst_n       in   1         asynchronous, active-low reset
//  adc_data    in   12        unsigned ADC code, 0..4095 = 0..2000 mV at the ADC
//  gain_ctrl   in   2         AGC gain code g; analog gain = 2^g
//  agc_stable  in   1         AGC stable flag, registered into vpp_stable
//  vpp_mv      out  MV_OUT_W  input-referred peak-to-peak amplitude, mV
//  vpp_gain    out  2         gain code that was in force for the reported window
//  vpp_clip    out  1         window contained code 0 or code 4095
//  vpp_stable  out  1         agc_stable sampled on the window's last sample
//  vpp_valid   out  1         1-cycle pulse; the four vpp_* outputs above are new
// BEHAVIOUR
//  - Reset (async assert, sync release): state=SETTLE, settle_cnt=0, sample_cnt=0,
//    min=4095, max=0, gain_q=0, and every output 0. Outputs hold between valid pulses.
//  - gain_q is gain_ctrl registered each cycle. A change is gain_ctrl != gain_q.
//  - FSM (one sample per clock):
//    SETTLE : settle_cnt++; samples are not used. When settle_cnt reaches SETTLE_CYCLES-1,
//             go to MEASURE and set min=4095, max=0, sample_cnt=0, clip=0.
//    MEASURE: min/max/clip update with adc_data; sample_cnt++. On the WINDOW-th sample, latch
//             diff=max'-min' (inclusive of that sample), gain, clip and agc_stable, then go
//             to CONVERT.
//    CONVERT: one cycle. The scaler (below) registers its result. Assert vpp_valid and go to
//             MEASURE with fresh min/max. The sample arriving this cycle counts as sample 0
//             of the next window, so there are no gaps between consecutive windows.
//  - Latency: vpp_valid is high in the cycle after the clock edge that captured sample
//    WINDOW-1 plus one more edge. That is 2 edges after the last sample.
//  - Scaling: vpp_mv = (diff * MV_SCALE_Q16) >> (16 + g), where MV_SCALE_Q16 = 32008
//    (round(2000*2^16/4095)). The product is 28 bits unsigned; truncate, do not round.
//    The result is saturated to 2^MV_OUT_W-1.
//  - Gain change in any state (including CONVERT) aborts the current window:
//    - no vpp_valid for it;
//    - go to SETTLE with settle_cnt=0.
//    A change during SETTLE restarts the count.
//  - Gain change on the same cycle as the WINDOW-th sample: abort wins and no valid is issued.
//  - Constant input gives diff=0, so vpp_mv=0. Single-sample spikes count toward min/max.
//  - agc_stable is reporting only. It never gates measurement.
// STRUCTURE
//  - agc_pkg holds:
//    - ADC_W=12, ADC_MAX=12'hFFF, MV_SCALE_Q16=32008, typedef logic [1:0] gain_code_t;
//    - typedef enum {SETTLE, MEASURE, CONVERT} agcm_state_t.
//  - Sub-module agc_code2mv: one registered stage. Inputs diff[11:0] and gain code g;
//    output is mV after multiply, shift and saturate. It is instantiated once and driven
//    during CONVERT.
//  - Top holds the FSM, the counters, min/max/clip, and the output registers.
// TESTING
//  1. Reset, g=0, 512-sample sine spanning codes 0..3685 (1800 mV).
//     -> first vpp_valid after 16+512 samples (+2 cycles); vpp_mv=1799 (+-2); vpp_clip=1
//     (hits 0); vpp_gain=0.
//  2. g=1, sine spanning codes 500..2957 (2457 codes = 600 mV input-referred).
//     -> vpp_mv in 599..600, vpp_gain=1, vpp_clip=0.
//  3. Switch g 1->2 at sample 200 of a window. -> no valid for that window. The next valid
//     comes exactly 16+512 samples after the change (+2 cycles) and is scaled with >>18.
//  4. Constant adc_data=2048 for 2 windows. -> two valids 512 cycles apart, vpp_mv=0,
//     vpp_clip=0.
//  5. Full swing 0..4095 at g=0. -> vpp_mv=1999 (+-1), vpp_clip=1. The same codes at g=3
//     -> vpp_mv=249 or 250.
//  6. Assert rst_n low for 3 cycles mid-window. -> all outputs 0 immediately (async). No
//     valid until 16+512 samples after release.

Source files
------------

// File: rtl/agc_pkg.sv
// Shared types and constants for the AGC amplitude meter.
package agc_pkg;

    localparam int              ADC_W        = 12;
    localparam logic [11:0]     ADC_MAX      = 12'hFFF;
    // round(2000 mV * 2^16 / 4095): mV per ADC code in Q16.
    localparam logic [14:0]     MV_SCALE_Q16 = 15'd32008;

    typedef logic [1:0] gain_code_t;

    typedef enum logic [1:0] {
        SETTLE  = 2'd0,
        MEASURE = 2'd1,
        CONVERT = 2'd2
    } agcm_state_t;

    // A code at either rail means the ADC input was clipped.
    function automatic logic is_clip_code(input logic [ADC_W-1:0] code);
        return (code == {ADC_W{1'b0}}) || (code == ADC_MAX);
    endfunction

endpackage

// File: rtl/agc_code2mv.sv
// Converts a peak-to-peak ADC code span into input-referred millivolts.
// One registered stage; the result holds until the next enabled cycle.
module agc_code2mv
    import agc_pkg::*;
#(
    parameter int MV_OUT_W = 12
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic [ADC_W-1:0]    diff_i,
    input  gain_code_t          g_i,
    output logic [MV_OUT_W-1:0] mv_o
);

    localparam int                PROD_W = 28;
    localparam logic [PROD_W-1:0] MV_SAT = PROD_W'((64'd1 << MV_OUT_W) - 64'd1);

    logic [PROD_W-1:0]   prod_s;
    logic [PROD_W-1:0]   shifted_s;
    logic [MV_OUT_W-1:0] mv_d;
    logic [MV_OUT_W-1:0] mv_q;

    // Multiply by the Q16 scale, divide out Q16 and the analog gain, saturate.
    always_comb begin
        prod_s    = PROD_W'(diff_i) * PROD_W'(MV_SCALE_Q16);
        shifted_s = prod_s >> (5'd16 + {3'b000, g_i});
        if (shifted_s > MV_SAT) begin
            mv_d = {MV_OUT_W{1'b1}};
        end else begin
            mv_d = shifted_s[MV_OUT_W-1:0];
        end
    end

    // Result register, loaded only when the meter converts a window.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mv_q <= {MV_OUT_W{1'b0}};
        end else if (en_i) begin
            mv_q <= mv_d;
        end else begin
            mv_q <= mv_q;
        end
    end

    assign mv_o = mv_q;

endmodule

// File: rtl/agc_amplitude_meter.sv
// Windowed peak-to-peak amplitude meter behind the AGC stage. Blanks while the
// analog gain settles, measures min/max over gap-free windows, and reports the
// span scaled back to the input in mV with the gain, clip and stable flags.
module agc_amplitude_meter
    import agc_pkg::*;
#(
    parameter int WINDOW        = 512,
    parameter int SETTLE_CYCLES = 16,
    parameter int MV_OUT_W      = 12
) (
    input  logic                adc_clk,
    input  logic                rst_n,
    input  logic [ADC_W-1:0]    adc_data,
    input  gain_code_t          gain_ctrl,
    input  logic                agc_stable,
    output logic [MV_OUT_W-1:0] vpp_mv,
    output gain_code_t          vpp_gain,
    output logic                vpp_clip,
    output logic                vpp_stable,
    output logic                vpp_valid
);

    localparam int                SCNT_W    = $clog2(WINDOW);
    localparam int                SETL_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(WINDOW - 1);
    localparam logic [SETL_W-1:0] SETL_ONE  = SETL_W'(1);
    localparam logic [SETL_W-1:0] SETL_LAST = SETL_W'(SETTLE_CYCLES - 1);

    agcm_state_t        state_q, state_d;
    logic [SETL_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [SCNT_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic [ADC_W-1:0]   min_q, min_d;
    logic [ADC_W-1:0]   max_q, max_d;
    logic               clip_q, clip_d;
    gain_code_t         gain_q;
    logic [ADC_W-1:0]   diff_q, diff_d;
    gain_code_t         lat_gain_q, lat_gain_d;
    logic               lat_clip_q, lat_clip_d;
    logic               lat_stable_q, lat_stable_d;
    gain_code_t         vpp_gain_q, vpp_gain_d;
    logic               vpp_clip_q, vpp_clip_d;
    logic               vpp_stable_q, vpp_stable_d;
    logic               vpp_valid_q, vpp_valid_d;

    logic               gain_change_s;
    logic [ADC_W-1:0]   min_upd_s;
    logic [ADC_W-1:0]   max_upd_s;
    logic               clip_upd_s;
    logic               conv_en_s;

    // Running extremes including the sample on the bus this cycle.
    always_comb begin
        gain_change_s = (gain_ctrl != gain_q);
        if (adc_data < min_q) begin
            min_upd_s = adc_data;
        end else begin
            min_upd_s = min_q;
        end
        if (adc_data > max_q) begin
            max_upd_s = adc_data;
        end else begin
            max_upd_s = max_q;
        end
        clip_upd_s = clip_q | is_clip_code(adc_data);
    end

    // Next-state logic: settle, measure a window, convert; any gain change aborts.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        sample_cnt_d = sample_cnt_q;
        min_d        = min_q;
        max_d        = max_q;
        clip_d       = clip_q;
        diff_d       = diff_q;
        lat_gain_d   = lat_gain_q;
        lat_clip_d   = lat_clip_q;
        lat_stable_d = lat_stable_q;
        vpp_gain_d   = vpp_gain_q;
        vpp_clip_d   = vpp_clip_q;
        vpp_stable_d = vpp_stable_q;
        vpp_valid_d  = 1'b0;
        conv_en_s    = 1'b0;

        case (state_q)
            SETTLE: begin
                if (gain_change_s) begin
                    settle_cnt_d = {SETL_W{1'b0}};
                end else if (settle_cnt_q == SETL_LAST) begin
                    state_d      = MEASURE;
                    settle_cnt_d = {SETL_W{1'b0}};
                    sample_cnt_d = {SCNT_W{1'b0}};
                    min_d        = ADC_MAX;
                    max_d        = {ADC_W{1'b0}};
                    clip_d       = 1'b0;
                end else begin
                    settle_cnt_d = settle_cnt_q + SETL_ONE;
                end
            end
            MEASURE: begin
                if (gain_change_s) begin
                    state_d      = SETTLE;
                    settle_cnt_d = {SETL_W{1'b0}};
                end else begin
                    min_d  = min_upd_s;
                    max_d  = max_upd_s;
                    clip_d = clip_upd_s;
                    if (sample_cnt_q == SCNT_LAST) begin
                        state_d      = CONVERT;
                        sample_cnt_d = {SCNT_W{1'b0}};
                        diff_d       = max_upd_s - min_upd_s;
                        lat_gain_d   = gain_q;
                        lat_clip_d   = clip_upd_s;
                        lat_stable_d = agc_stable;
                    end else begin
                        sample_cnt_d = sample_cnt_q + SCNT_ONE;
                    end
                end
            end
            CONVERT: begin
                if (gain_change_s) begin
                    state_d      = SETTLE;
                    settle_cnt_d = {SETL_W{1'b0}};
                end else begin
                    // This cycle's sample opens the next window.
                    state_d      = MEASURE;
                    conv_en_s    = 1'b1;
                    vpp_valid_d  = 1'b1;
                    vpp_gain_d   = lat_gain_q;
                    vpp_clip_d   = lat_clip_q;
                    vpp_stable_d = lat_stable_q;
                    min_d        = adc_data;
                    max_d        = adc_data;
                    clip_d       = is_clip_code(adc_data);
                    sample_cnt_d = SCNT_ONE;
                end
            end
            default: begin
                state_d      = SETTLE;
                settle_cnt_d = {SETL_W{1'b0}};
            end
        endcase
    end

    // State, counters, window statistics and output registers.
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SETTLE;
            settle_cnt_q <= {SETL_W{1'b0}};
            sample_cnt_q <= {SCNT_W{1'b0}};
            min_q        <= ADC_MAX;
            max_q        <= {ADC_W{1'b0}};
            clip_q       <= 1'b0;
            gain_q       <= 2'b00;
            diff_q       <= {ADC_W{1'b0}};
            lat_gain_q   <= 2'b00;
            lat_clip_q   <= 1'b0;
            lat_stable_q <= 1'b0;
            vpp_gain_q   <= 2'b00;
            vpp_clip_q   <= 1'b0;
            vpp_stable_q <= 1'b0;
            vpp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            min_q        <= min_d;
            max_q        <= max_d;
            clip_q       <= clip_d;
            gain_q       <= gain_ctrl;
            diff_q       <= diff_d;
            lat_gain_q   <= lat_gain_d;
            lat_clip_q   <= lat_clip_d;
            lat_stable_q <= lat_stable_d;
            vpp_gain_q   <= vpp_gain_d;
            vpp_clip_q   <= vpp_clip_d;
            vpp_stable_q <= vpp_stable_d;
            vpp_valid_q  <= vpp_valid_d;
        end
    end

    agc_code2mv #(
        .MV_OUT_W (MV_OUT_W)
    ) u_code2mv (
        .clk_i  (adc_clk),
        .rst_ni (rst_n),
        .en_i   (conv_en_s),
        .diff_i (diff_q),
        .g_i    (lat_gain_q),
        .mv_o   (vpp_mv)
    );

    assign vpp_gain   = vpp_gain_q;
    assign vpp_clip   = vpp_clip_q;
    assign vpp_stable = vpp_stable_q;
    assign vpp_valid  = vpp_valid_q;

endmodule
